// File: rtl/l1_norm_stream.sv
// Streaming L1 normalizer: buffers one signed vector, divides 2^(FRAC_W+SUM_W) by its
// L1 sum with a bit-serial restoring divider, then streams x[i]*R scaled to signed Q1.FRAC_W.
module l1_norm_stream #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 8,
  parameter int FRAC_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W:0]   out_data,
  output logic              out_last,
  output logic              zero_sum
);

  localparam int OUT_W = FRAC_W + 1;
  localparam int SUM_W = DATA_W + $clog2(VEC_LEN);
  localparam int Q_W   = FRAC_W + SUM_W + 1;
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int CNT_W = $clog2(Q_W);
  localparam int PRD_W = DATA_W + Q_W;
  localparam int P_W   = PRD_W - SUM_W;

  typedef enum logic [1:0] {S_LOAD, S_DIV, S_EMIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [DATA_W-1:0]  r_buf [VEC_LEN];
  logic [IDX_W-1:0]   r_idx;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_rem;
  logic [Q_W-1:0]     r_quot;
  logic [CNT_W-1:0]   r_cnt;

  function automatic logic [DATA_W-1:0] abs_u(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  logic              w_in_fire, w_out_fire, w_idx_last, w_div_last, w_div_bit, w_rem_ge;
  logic [SUM_W:0]    w_rem_sh;
  logic [DATA_W-1:0] w_x, w_in_abs, w_x_abs;
  logic              w_neg;
  logic [PRD_W-1:0]  w_prod;
  logic [P_W-1:0]    w_p, w_lim;
  logic [OUT_W-1:0]  w_mag, w_y;

  assign in_ready   = (r_state == S_LOAD) & ~rst;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign w_idx_last = (r_idx == IDX_W'(VEC_LEN - 1));
  assign w_div_last = (r_cnt == CNT_W'(Q_W - 1));
  assign w_in_abs   = abs_u(in_data);

  // The dividend is a single 1 in its MSB, so only the first step shifts in a 1.
  assign w_div_bit  = (r_cnt == '0);
  assign w_rem_sh   = {r_rem, w_div_bit};
  assign w_rem_ge   = (w_rem_sh >= {1'b0, r_acc});

  assign w_x     = r_buf[r_idx];
  assign w_neg   = w_x[DATA_W-1];
  assign w_x_abs = abs_u(w_x);
  assign w_prod  = PRD_W'(w_x_abs) * PRD_W'(r_quot);
  assign w_p     = P_W'(w_prod >> SUM_W);
  // Negative results may reach exactly -1.0; positive ones stop one LSB short of +1.0.
  assign w_lim   = w_neg ? (P_W'(1) << FRAC_W) : ((P_W'(1) << FRAC_W) - P_W'(1));
  assign w_mag   = OUT_W'((w_p > w_lim) ? w_lim : w_p);
  assign w_y     = w_neg ? (~w_mag + OUT_W'(1)) : w_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: assign every always_comb output a default before the case so no path infers a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_in_fire && w_idx_last) w_state_nxt = S_DIV;
      S_DIV:   if ((r_acc == '0) || w_div_last) w_state_nxt = S_EMIT;
      S_EMIT:  if (w_out_fire && out_last) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // NOTE: the vector buffer is plain storage with no reset; stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_in_fire) r_buf[r_idx] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_idx     <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      zero_sum  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_acc <= r_acc + SUM_W'(w_in_abs);
            r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            r_rem <= '0;
            r_cnt <= '0;
          end
        end
        S_DIV: begin
          if (r_acc == '0) begin
            r_quot   <= '0;
            zero_sum <= 1'b1;
          end else begin
            r_quot <= {r_quot[Q_W-2:0], w_rem_ge};
            r_rem  <= SUM_W'(w_rem_ge ? (w_rem_sh - {1'b0, r_acc}) : w_rem_sh);
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        S_EMIT: begin
          if (!out_valid || out_ready) begin
            if (out_valid && out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              r_acc     <= '0;
              zero_sum  <= 1'b0;
              r_idx     <= '0;
            end else begin
              out_valid <= 1'b1;
              out_data  <= w_y;
              out_last  <= w_idx_last;
              r_idx     <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/l1_norm_stream.md
Name: l1_norm_stream

Overview:
- Streaming L1 normalization of fixed-length signed vectors: y[i] = x[i] / sum(|x[j]|), with output in signed fixed point.
- The block buffers one vector, accumulates the L1 sum, computes one reciprocal with a sequential restoring divider, then emits the scaled elements with valid/ready backpressure.
- It is the parametrised successor of the single-word L1Norm operator stage and sits in the operator datapath between the stream source and the downstream consumer.

Parameters:
- DATA_W, 16, input element width (signed two's complement).
- VEC_LEN, 8, elements per vector (>=2).
- FRAC_W, 15, output fractional bits. The output is signed, OUT_W = FRAC_W+1.
- SUM_W (derived), DATA_W+clog2(VEC_LEN), accumulator width.
- Q_W (derived), FRAC_W+SUM_W+1, reciprocal width and divider cycle count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an input element.
- in_data  in  DATA_W  signed input element.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts the output element.
- out_data  out  OUT_W  signed normalized element.
- out_last  out  1  high with the final element of the vector.
- zero_sum  out  1  sticky for the current vector: its L1 sum was 0.

Behaviour:
- Reset (async, rst=1): state=LOAD, counters=0, accumulator=0. Outputs: in_ready=0 while rst=1, out_valid=0, out_data=0, out_last=0, zero_sum=0. The buffer contents are don't-care. Reset mid-vector discards the partial vector.
- FSM states: LOAD, DIV, EMIT.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, buf[idx]<=in_data, acc<=acc+|in_data|, idx++.
  - |x| is computed at DATA_W bits unsigned, so |-2^(DATA_W-1)| = 2^(DATA_W-1) with no overflow.
  - When element VEC_LEN-1 is accepted: go to DIV, idx<=0, in_ready=0 from the next cycle.
- DIV:
  - Restoring division R = floor(2^(FRAC_W+SUM_W) / acc), one quotient bit per cycle, exactly Q_W cycles.
  - If acc==0: skip the division, set R=0 and zero_sum=1.
  - Then go to EMIT.
- EMIT, per element:
  - p = (|buf[idx]| * R) >> SUM_W.
  - Magnitude m = min(p, 2^FRAC_W) for a negative x, and min(p, 2^FRAC_W-1) for a non-negative x (positive saturation; the only overflow case is x = sum with sum a power of two).
  - out_data = x<0 ? -m : m.
  - out_data and out_last are registered. out_valid rises the first EMIT cycle; the first element is presented the cycle after DIV completes.
  - While out_valid & !out_ready: out_data, out_last and out_valid hold stable.
  - On handshake: present the next element next cycle (1 element/cycle at full throughput).
  - After the out_last handshake: out_valid<=0, acc<=0, zero_sum<=0, go to LOAD.
- Latency from last input accepted to first out_valid: Q_W+1 cycles when acc!=0, 2 cycles when acc==0.
- Input and output phases never overlap (single buffer). in_ready=0 throughout DIV and EMIT.
- Truncation is toward zero on magnitude. No rounding.

Test Plan:
- Eight inputs of 1 (defaults) -> acc=8, R=2^31, eight outputs of 4096 (0.125). out_last only on the 8th. First out_valid 36 cycles after the last input.
- Inputs [16384, -16384, 0, 0, 0, 0, 0, 0] -> R=2^19, outputs [16384, -16384, 0, 0, 0, 0, 0, 0].
- Boundary values:
  - -32768 then seven 0 -> output -32768 (exact -1.0).
  - 16384 then seven 0 -> positive saturation to 32767.
  - 32767 then seven 0 -> R=524304, output 32767.
- All-zero vector -> zero_sum=1 during EMIT, eight outputs of 0, first out_valid 2 cycles after the last input. zero_sum clears after out_last.
- Backpressure:
  - Random out_ready (about 50%) -> out_data and out_last are stable while stalled, no element is lost or duplicated, in_ready=0 until the final handshake.
  - in_valid gaps during LOAD are tolerated.
- Assert rst mid-LOAD (after 3 inputs) and again mid-DIV -> all outputs return to reset values immediately. The next full vector normalizes correctly with no residue from the aborted one.
